// File: rtl/mem_access_unit.sv
// mem_access_unit
// Data-memory load/store stage of the simple MIPS core. It takes one memory
// op per handshake from execute and runs it on a single-outstanding req/ack
// bus. Stores are lane-steered and loads are extracted and extended. Loads
// are returned to writeback. Misaligned accesses and bus timeouts are raised
// as one-cycle exceptions.

module mem_access_unit #(
  parameter bit          BIG_ENDIAN     = 1'b0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [5:0]  op_code,
  input  logic [31:0] op_addr,
  input  logic [31:0] op_wdata,
  input  logic [4:0]  op_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc_valid,
  output logic [1:0]  exc_code,
  output logic [31:0] exc_badaddr
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_RESP = 3'd2;
  localparam logic [2:0] ST_EXC  = 3'd3;
  localparam logic [2:0] ST_NOP  = 3'd4;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] EXC_LOAD_MISALIGN  = 2'b01;
  localparam logic [1:0] EXC_STORE_MISALIGN = 2'b10;
  localparam logic [1:0] EXC_BUS_TIMEOUT    = 2'b11;

  // The counter is 16 bits wide because the limit can be as large as 65535.
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  logic [2:0]  state;
  logic [15:0] timeout_cnt;
  logic [15:0] cnt_next;

  // The op is latched at accept. Execute may change its outputs as soon as the
  // handshake is done.
  logic        q_is_load;
  logic [1:0]  q_size;
  logic        q_signed;
  logic [31:0] q_addr;
  logic [4:0]  q_rd;

  // Decoded view of the op currently presented by execute.
  logic        in_load;
  logic        in_store;
  logic        in_signed;
  logic [1:0]  in_size;
  logic        in_supported;
  logic        in_misaligned;
  logic [1:0]  in_byte_lane;
  logic        in_half_lane;
  logic [3:0]  in_be;
  logic [31:0] in_wdata;

  // Load data extraction from the bus, using the lanes of the latched op.
  logic [1:0]  q_byte_lane;
  logic        q_half_lane;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_result;

  logic        accept;

  // Lane numbering flips for big-endian so that the lowest address holds the MSB.
  function automatic logic [1:0] byte_lane(input logic [1:0] a);
    byte_lane = BIG_ENDIAN ? (2'd3 - a) : a;
  endfunction

  function automatic logic half_lane(input logic a1);
    half_lane = BIG_ENDIAN ? ~a1 : a1;
  endfunction

  assign op_ready  = (state == ST_IDLE);
  assign mem_req   = (state == ST_REQ);
  assign wb_valid  = (state == ST_RESP);
  assign exc_valid = (state == ST_EXC);
  assign accept    = op_ready && op_valid;
  assign cnt_next  = timeout_cnt + 16'd1;

  // Decode the incoming opcode into direction, access size and signedness.
  always_comb begin
    in_load   = 1'b0;
    in_store  = 1'b0;
    in_signed = 1'b0;
    in_size   = SZ_WORD;
    case (op_code)
      OP_LB:  begin in_load  = 1'b1; in_size = SZ_BYTE; in_signed = 1'b1; end
      OP_LBU: begin in_load  = 1'b1; in_size = SZ_BYTE; end
      OP_LH:  begin in_load  = 1'b1; in_size = SZ_HALF; in_signed = 1'b1; end
      OP_LHU: begin in_load  = 1'b1; in_size = SZ_HALF; end
      OP_LW:  begin in_load  = 1'b1; in_size = SZ_WORD; end
      OP_SB:  begin in_store = 1'b1; in_size = SZ_BYTE; end
      OP_SH:  begin in_store = 1'b1; in_size = SZ_HALF; end
      OP_SW:  begin in_store = 1'b1; in_size = SZ_WORD; end
      default: begin end
    endcase
  end

  // Work out alignment, byte enables and replicated store data for the presented op.
  always_comb begin
    in_supported  = in_load || in_store;
    in_byte_lane  = byte_lane(op_addr[1:0]);
    in_half_lane  = half_lane(op_addr[1]);
    in_misaligned = 1'b0;
    in_be         = 4'hF;
    in_wdata      = op_wdata;
    case (in_size)
      SZ_HALF: in_misaligned = op_addr[0];
      SZ_WORD: in_misaligned = (op_addr[1:0] != 2'b00);
      default: in_misaligned = 1'b0;
    endcase
    if (in_store) begin
      case (in_size)
        SZ_BYTE: begin
          in_be    = 4'b0001 << in_byte_lane;
          in_wdata = {4{op_wdata[7:0]}};
        end
        SZ_HALF: begin
          in_be    = in_half_lane ? 4'b1100 : 4'b0011;
          in_wdata = {2{op_wdata[15:0]}};
        end
        default: begin
          in_be    = 4'hF;
          in_wdata = op_wdata;
        end
      endcase
    end
  end

  // Pick the addressed byte or half out of the read word and extend it.
  always_comb begin
    q_byte_lane = byte_lane(q_addr[1:0]);
    q_half_lane = half_lane(q_addr[1]);
    ld_byte     = mem_rdata[{q_byte_lane, 3'b000} +: 8];
    ld_half     = mem_rdata[{q_half_lane, 4'b0000} +: 16];
    case (q_size)
      SZ_BYTE: ld_result = q_signed ? {{24{ld_byte[7]}}, ld_byte} : {24'h0, ld_byte};
      SZ_HALF: ld_result = q_signed ? {{16{ld_half[15]}}, ld_half} : {16'h0, ld_half};
      default: ld_result = mem_rdata;
    endcase
  end

  // Main sequencer. An ack always beats a timeout that would expire on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      timeout_cnt <= 16'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            timeout_cnt <= 16'd0;
            if (!in_supported) begin
              state <= ST_NOP;
            end else if (in_misaligned) begin
              state <= ST_EXC;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (mem_ack) begin
            state <= q_is_load ? ST_RESP : ST_IDLE;
          end else if (cnt_next == TIMEOUT_LIMIT) begin
            state       <= ST_EXC;
            timeout_cnt <= cnt_next;
          end else begin
            timeout_cnt <= cnt_next;
          end
        end
        ST_RESP: state <= ST_IDLE;
        ST_EXC:  state <= ST_IDLE;
        ST_NOP:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture the attributes of every accepted op for use in later states.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_is_load <= 1'b0;
      q_size    <= SZ_WORD;
      q_signed  <= 1'b0;
      q_addr    <= 32'h0;
      q_rd      <= 5'd0;
    end else if (accept) begin
      q_is_load <= in_load;
      q_size    <= in_size;
      q_signed  <= in_signed;
      q_addr    <= op_addr;
      q_rd      <= op_rd;
    end
  end

  // Bus request fields. They are loaded only for ops that go to the bus, so they stay frozen until the ack.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_be    <= 4'h0;
      mem_wdata <= 32'h0;
    end else if (accept && in_supported && !in_misaligned) begin
      mem_we    <= in_store;
      mem_addr  <= {op_addr[31:2], 2'b00};
      mem_be    <= in_be;
      mem_wdata <= in_wdata;
    end
  end

  // Read data is sampled only on the acking edge of a load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_rd   <= 5'd0;
      wb_data <= 32'h0;
    end else if ((state == ST_REQ) && mem_ack && q_is_load) begin
      wb_rd   <= q_rd;
      wb_data <= ld_result;
    end
  end

  // Exception cause and address, recorded when the EXC state is entered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exc_code    <= 2'b00;
      exc_badaddr <= 32'h0;
    end else if (accept && in_supported && in_misaligned) begin
      exc_code    <= in_load ? EXC_LOAD_MISALIGN : EXC_STORE_MISALIGN;
      exc_badaddr <= op_addr;
    end else if ((state == ST_REQ) && !mem_ack && (cnt_next == TIMEOUT_LIMIT)) begin
      exc_code    <= EXC_BUS_TIMEOUT;
      exc_badaddr <= q_addr;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
// Two instances run side by side on identical stimulus: one little-endian and
// one big-endian, both with a short bus timeout. A transaction-level model
// computes the expected outputs for every cycle. Directed ops reproduce the
// reference scenarios, and a random stream follows them.

module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk;
  logic        reset;
  logic        op_valid;
  logic [5:0]  op_code;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [4:0]  op_rd;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        le_op_ready, le_mem_req, le_mem_we, le_wb_valid, le_exc_valid;
  logic [31:0] le_mem_addr, le_mem_wdata, le_wb_data, le_exc_badaddr;
  logic [3:0]  le_mem_be;
  logic [4:0]  le_wb_rd;
  logic [1:0]  le_exc_code;

  logic        be_op_ready, be_mem_req, be_mem_we, be_wb_valid, be_exc_valid;
  logic [31:0] be_mem_addr, be_mem_wdata, be_wb_data, be_exc_badaddr;
  logic [3:0]  be_mem_be;
  logic [4:0]  be_wb_rd;
  logic [1:0]  be_exc_code;

  int checks = 0;
  int errors = 0;
  bit check_en = 0;

  // Expected outputs for the current cycle, set by the stimulus tasks.
  logic        exp_ready, exp_req, exp_we, exp_wb, exp_exc;
  logic [31:0] exp_addr, exp_wdata, exp_wb_le, exp_wb_be, exp_badaddr;
  logic [3:0]  exp_be_le, exp_be_be;
  logic [4:0]  exp_wb_rd;
  logic [1:0]  exp_exc_code;

  // Values captured from the DUT for the literal checks in the directed tests.
  int          le_req_cycles = 0;
  int          le_wb_cnt = 0;
  int          le_exc_cnt = 0;
  logic [31:0] last_le_addr, last_le_wdata, last_le_wb, last_be_wb, last_le_badaddr;
  logic [3:0]  last_le_be;
  logic        last_le_we;
  logic [1:0]  last_le_exc_code;

  mem_access_unit #(.BIG_ENDIAN(1'b0), .TIMEOUT_CYCLES(TO)) dut_le (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(le_op_ready),
    .op_code(op_code), .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
    .mem_req(le_mem_req), .mem_we(le_mem_we), .mem_addr(le_mem_addr), .mem_be(le_mem_be),
    .mem_wdata(le_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(le_wb_valid), .wb_rd(le_wb_rd), .wb_data(le_wb_data),
    .exc_valid(le_exc_valid), .exc_code(le_exc_code), .exc_badaddr(le_exc_badaddr)
  );

  mem_access_unit #(.BIG_ENDIAN(1'b1), .TIMEOUT_CYCLES(TO)) dut_be (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_ready(be_op_ready),
    .op_code(op_code), .op_addr(op_addr), .op_wdata(op_wdata), .op_rd(op_rd),
    .mem_req(be_mem_req), .mem_we(be_mem_we), .mem_addr(be_mem_addr), .mem_be(be_mem_be),
    .mem_wdata(be_mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(be_wb_valid), .wb_rd(be_wb_rd), .wb_data(be_wb_data),
    .exc_valid(be_exc_valid), .exc_code(be_exc_code), .exc_badaddr(be_exc_badaddr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit m_is_load(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) || (op == 6'h24) || (op == 6'h25);
  endfunction

  function automatic bit m_supported(input logic [5:0] op);
    return m_is_load(op) || (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
  endfunction

  function automatic int m_size(input logic [5:0] op);
    if (op == 6'h20 || op == 6'h24 || op == 6'h28) return 1;
    if (op == 6'h21 || op == 6'h25 || op == 6'h29) return 2;
    return 4;
  endfunction

  function automatic bit m_misaligned(input logic [5:0] op, input logic [31:0] addr);
    return (int'(addr[1:0]) % m_size(op)) != 0;
  endfunction

  function automatic int m_byte_lane(input logic [31:0] addr, input bit big);
    return big ? 3 - int'(addr[1:0]) : int'(addr[1:0]);
  endfunction

  function automatic int m_half_lane(input logic [31:0] addr, input bit big);
    return big ? 1 - int'(addr[1]) : int'(addr[1]);
  endfunction

  function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] addr, input bit big);
    if (m_is_load(op) || m_size(op) == 4) return 4'hF;
    if (m_size(op) == 1) return 4'(1 << m_byte_lane(addr, big));
    return (m_half_lane(addr, big) == 1) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] wd);
    if (m_size(op) == 1) return {4{wd[7:0]}};
    if (m_size(op) == 2) return {2{wd[15:0]}};
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] addr,
                                         input logic [31:0] rdata, input bit big);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(rdata >> (8 * m_byte_lane(addr, big)));
    h = 16'(rdata >> (16 * m_half_lane(addr, big)));
    case (op)
      6'h20:   return {{24{b[7]}}, b};
      6'h24:   return {24'h0, b};
      6'h21:   return {{16{h[15]}}, h};
      6'h25:   return {16'h0, h};
      default: return rdata;
    endcase
  endfunction

  // ---------------- checking ----------------
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model, plus captures for directed checks.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("le.op_ready", le_op_ready, exp_ready);
      checkOutput("be.op_ready", be_op_ready, exp_ready);
      checkOutput("le.mem_req", le_mem_req, exp_req);
      checkOutput("be.mem_req", be_mem_req, exp_req);
      if (exp_req) begin
        checkOutput("le.mem_we", le_mem_we, exp_we);
        checkOutput("be.mem_we", be_mem_we, exp_we);
        checkOutput("le.mem_addr", le_mem_addr, exp_addr);
        checkOutput("be.mem_addr", be_mem_addr, exp_addr);
        checkOutput("le.mem_be", le_mem_be, exp_be_le);
        checkOutput("be.mem_be", be_mem_be, exp_be_be);
        if (exp_we) begin
          checkOutput("le.mem_wdata", le_mem_wdata, exp_wdata);
          checkOutput("be.mem_wdata", be_mem_wdata, exp_wdata);
        end
      end
      checkOutput("le.wb_valid", le_wb_valid, exp_wb);
      checkOutput("be.wb_valid", be_wb_valid, exp_wb);
      if (exp_wb) begin
        checkOutput("le.wb_rd", le_wb_rd, exp_wb_rd);
        checkOutput("be.wb_rd", be_wb_rd, exp_wb_rd);
        checkOutput("le.wb_data", le_wb_data, exp_wb_le);
        checkOutput("be.wb_data", be_wb_data, exp_wb_be);
      end
      checkOutput("le.exc_valid", le_exc_valid, exp_exc);
      checkOutput("be.exc_valid", be_exc_valid, exp_exc);
      if (exp_exc) begin
        checkOutput("le.exc_code", le_exc_code, exp_exc_code);
        checkOutput("be.exc_code", be_exc_code, exp_exc_code);
        checkOutput("le.exc_badaddr", le_exc_badaddr, exp_badaddr);
        checkOutput("be.exc_badaddr", be_exc_badaddr, exp_badaddr);
      end
    end
    if (le_mem_req) begin
      le_req_cycles <= le_req_cycles + 1;
      last_le_addr  <= le_mem_addr;
      last_le_be    <= le_mem_be;
      last_le_we    <= le_mem_we;
      last_le_wdata <= le_mem_wdata;
    end
    if (le_wb_valid) begin
      le_wb_cnt  <= le_wb_cnt + 1;
      last_le_wb <= le_wb_data;
    end
    if (be_wb_valid) last_be_wb <= be_wb_data;
    if (le_exc_valid) begin
      le_exc_cnt       <= le_exc_cnt + 1;
      last_le_exc_code <= le_exc_code;
      last_le_badaddr  <= le_exc_badaddr;
    end
  end

  // ---------------- stimulus ----------------
  task automatic setIdle();
    exp_ready = 1'b1;
    exp_req   = 1'b0;
    exp_wb    = 1'b0;
    exp_exc   = 1'b0;
  endtask

  task automatic idleCycles(input int n, input bit stray_ack);
    for (int i = 0; i < n; i++) begin
      mem_ack   = stray_ack ? 1'b1 : 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
  endtask

  // Presents one op in an IDLE cycle and walks the model through it. The bus acks after 'delay'
  // REQ cycles (0 = first cycle); delay >= TO never acks.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [4:0] rd, input int delay, input logic [31:0] rdata);
    bit acked;
    op_valid  = 1'b1;
    op_code   = op;
    op_addr   = addr;
    op_wdata  = wdata;
    op_rd     = rd;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    setIdle();
    @(posedge clk); #1;
    op_valid  = 1'b0;
    op_code   = 6'($urandom);
    op_addr   = $urandom;
    op_wdata  = $urandom;
    op_rd     = 5'($urandom);
    exp_ready = 1'b0;
    if (!m_supported(op)) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end else if (m_misaligned(op, addr)) begin
      exp_exc      = 1'b1;
      exp_exc_code = m_is_load(op) ? 2'b01 : 2'b10;
      exp_badaddr  = addr;
      mem_ack      = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end else begin
      exp_req   = 1'b1;
      exp_we    = !m_is_load(op);
      exp_addr  = {addr[31:2], 2'b00};
      exp_be_le = m_be(op, addr, 1'b0);
      exp_be_be = m_be(op, addr, 1'b1);
      exp_wdata = m_wdata(op, wdata);
      acked     = 1'b0;
      for (int k = 0; k < TO; k++) begin
        if (k == delay) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = $urandom;
        end
        @(posedge clk); #1;
        if (k == delay) begin
          acked = 1'b1;
          break;
        end
      end
      exp_req = 1'b0;
      mem_ack = 1'b0;
      if (acked && m_is_load(op)) begin
        exp_wb    = 1'b1;
        exp_wb_rd = rd;
        exp_wb_le = m_load(op, addr, rdata, 1'b0);
        exp_wb_be = m_load(op, addr, rdata, 1'b1);
        mem_ack   = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end else if (!acked) begin
        exp_exc      = 1'b1;
        exp_exc_code = 2'b11;
        exp_badaddr  = addr;
        mem_ack      = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
    end
    mem_ack = 1'b0;
    setIdle();
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int req0, wb0, exc0;
    logic [5:0]  ops [10];
    logic [5:0]  op;
    logic [31:0] a;
    ops = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B, 6'h22, 6'h00};

    reset = 1'b1; op_valid = 1'b0; op_code = 6'h0; op_addr = 32'h0; op_wdata = 32'h0;
    op_rd = 5'd0; mem_ack = 1'b0; mem_rdata = 32'h0;
    setIdle();
    repeat (2) @(posedge clk);
    #1;
    $display("[TB] reset values");
    checkOutput("rst.op_ready", le_op_ready, 32'd1);
    checkOutput("rst.mem_req", le_mem_req, 32'd0);
    checkOutput("rst.mem_we", le_mem_we, 32'd0);
    checkOutput("rst.mem_addr", le_mem_addr, 32'd0);
    checkOutput("rst.mem_be", le_mem_be, 32'd0);
    checkOutput("rst.mem_wdata", le_mem_wdata, 32'd0);
    checkOutput("rst.wb_valid", le_wb_valid, 32'd0);
    checkOutput("rst.wb_rd", le_wb_rd, 32'd0);
    checkOutput("rst.wb_data", le_wb_data, 32'd0);
    checkOutput("rst.exc_valid", le_exc_valid, 32'd0);
    checkOutput("rst.exc_code", le_exc_code, 32'd0);
    checkOutput("rst.exc_badaddr", be_exc_badaddr, 32'd0);
    reset = 1'b0;
    check_en = 1'b1;
    idleCycles(2, 1'b0);

    $display("[TB] directed: LW with immediate ack");
    applyStimulus(6'h23, 32'h1001_0004, 32'h0, 5'd9, 0, 32'hDEAD_BEEF);
    checkOutput("lw.wb_data", last_le_wb, 32'hDEAD_BEEF);
    checkOutput("lw.mem_addr", last_le_addr, 32'h1001_0004);
    checkOutput("lw.mem_be", last_le_be, 32'hF);

    $display("[TB] directed: LB / LBU lane extraction");
    applyStimulus(6'h20, 32'h1001_0003, 32'h0, 5'd3, 1, 32'h80FF_0011);
    checkOutput("lb.le", last_le_wb, 32'hFFFF_FF80);
    checkOutput("lb.be", last_be_wb, 32'h0000_0011);
    applyStimulus(6'h24, 32'h1001_0003, 32'h0, 5'd0, 0, 32'h80FF_0011);
    checkOutput("lbu.le", last_le_wb, 32'h0000_0080);

    $display("[TB] directed: SH with three wait cycles");
    req0 = le_req_cycles; wb0 = le_wb_cnt;
    applyStimulus(6'h29, 32'h1001_0002, 32'h0000_ABCD, 5'd1, 3, 32'h0);
    checkOutput("sh.req_cycles", le_req_cycles - req0, 32'd4);
    checkOutput("sh.mem_wdata", last_le_wdata, 32'hABCD_ABCD);
    checkOutput("sh.mem_be", last_le_be, 32'hC);
    checkOutput("sh.mem_we", last_le_we, 32'd1);
    checkOutput("sh.no_wb", le_wb_cnt - wb0, 32'd0);

    $display("[TB] directed: misaligned accesses");
    req0 = le_req_cycles;
    applyStimulus(6'h23, 32'h1001_0006, 32'h0, 5'd2, 0, 32'h0);
    checkOutput("lw_mis.code", last_le_exc_code, 32'd1);
    checkOutput("lw_mis.badaddr", last_le_badaddr, 32'h1001_0006);
    applyStimulus(6'h2B, 32'h1001_0001, 32'h1234_5678, 5'd2, 0, 32'h0);
    checkOutput("sw_mis.code", last_le_exc_code, 32'd2);
    checkOutput("mis.no_req", le_req_cycles - req0, 32'd0);

    $display("[TB] directed: bus timeout then stray ack");
    req0 = le_req_cycles;
    applyStimulus(6'h23, 32'h1001_0008, 32'h0, 5'd4, 99, 32'h0);
    checkOutput("to.req_cycles", le_req_cycles - req0, 32'd4);
    checkOutput("to.code", last_le_exc_code, 32'd3);
    wb0 = le_wb_cnt; exc0 = le_exc_cnt;
    idleCycles(3, 1'b1);
    checkOutput("stray.no_wb", le_wb_cnt - wb0, 32'd0);
    checkOutput("stray.no_exc", le_exc_cnt - exc0, 32'd0);

    $display("[TB] directed: reset during a request");
    op_valid = 1'b1; op_code = 6'h23; op_addr = 32'h2000_0010; op_rd = 5'd7;
    @(posedge clk); #1;
    op_valid = 1'b0;
    exp_ready = 1'b0; exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h2000_0010;
    exp_be_le = 4'hF; exp_be_be = 4'hF;
    @(posedge clk); #1;
    check_en = 1'b0;
    #2 reset = 1'b1;
    #1;
    checkOutput("rst_mid.le_req", le_mem_req, 32'd0);
    checkOutput("rst_mid.be_req", be_mem_req, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    setIdle();
    check_en = 1'b1;
    idleCycles(1, 1'b0);
    applyStimulus(6'h21, 32'h2000_0012, 32'h0, 5'd5, 2, 32'h8001_7FFE);
    checkOutput("post_rst.lh", last_le_wb, 32'hFFFF_8001);

    $display("[TB] random stream");
    for (int n = 0; n < 400; n++) begin
      op = ops[$urandom_range(0, 9)];
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (m_size(op) == 4) a[1:0] = 2'b00;
        else if (m_size(op) == 2) a[0] = 1'b0;
      end
      applyStimulus(op, a, $urandom, 5'($urandom), $urandom_range(0, 5), $urandom);
      idleCycles($urandom_range(0, 2), 1'b0);
    end

    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
